uart_rx_controller: RTL and testbench

Frame sequencer for the UART receive shift-register datapath. It synchronises the raw serial line and detects the start bit. It times each bit at the configured clock-per-bit rate and issues one clear strobe plus one shift strobe per data bit, each with a sampled bit value, to the external shift register. It checks the stop bit and reports frame done or framing error. It sits between the serial pin and the receive datapath, replacing free-running per-clock shifting with properly framed sampling.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_rx_controller.sv | 123 ++++++++++++
 tb/tb_uart_rx_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive frame sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;
    localparam int UART_DEFAULT_DATA_BITS    = 8;

    // Width of a counter that has to reach clks - 1; never narrower than one bit.
    function automatic int baud_cnt_width(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate counter: flags the mid-bit and end-of-bit points of a serial bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign half_tick = (cnt == HALF_CNT);
    assign full_tick = (cnt == FULL_CNT);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer: synchronises the line, finds the start bit and
// strobes each mid-bit sample into an external shift register.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DEFAULT_DATA_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       enable,
    output logic       clr_datapath,
    output logic       shift_en,
    output logic       sample_bit,
    output logic [2:0] bit_idx,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    rx_state_t  state, state_next;
    logic [2:0] bit_idx_next;
    logic       rx_meta, rx_s, rx_q;
    logic       half_tick, full_tick, timer_clear;

    // Synchroniser resets to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        clr_datapath = 1'b0;
        shift_en     = 1'b0;
        sample_bit   = 1'b0;
        frame_done   = 1'b0;
        frame_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && rx_q && !rx_s) begin
                    state_next   = START;
                    clr_datapath = 1'b1;
                end
            end
            START: begin
                if (half_tick) begin
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    shift_en   = 1'b1;
                    sample_bit = rx_s;
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (full_tick) begin
                    if (rx_s) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Restart the bit period on every state change and after each data sample.
    assign timer_clear = (state_next != state) || shift_en;
    assign busy        = (state != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: frame table plus hand-written corner sequences.
module tb_uart_rx_controller;

    localparam int CPB = 16;
    localparam int NB  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       enable = 1'b0;
    logic       clr_datapath, shift_en, sample_bit, frame_done, frame_err, busy;
    logic [2:0] bit_idx;

    uart_rx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .enable      (enable),
        .clr_datapath(clr_datapath),
        .shift_en    (shift_en),
        .sample_bit  (sample_bit),
        .bit_idx     (bit_idx),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Event log filled by the output monitor.
    int         n_clr, n_shift, n_done, n_err, n_overlap, n_busy_cyc, n_busy_after_done;
    int         clr_cyc_last, done_cyc_first, edge_cyc;
    logic       prev_done;
    logic       samp [16];
    logic [2:0] idxv [16];
    int         scyc [16];

    task automatic clear_log();
        n_clr = 0; n_shift = 0; n_done = 0; n_err = 0; n_overlap = 0;
        n_busy_cyc = 0; n_busy_after_done = 0;
        clr_cyc_last = -1; done_cyc_first = -1; prev_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            samp[i] = 1'b0; idxv[i] = '0; scyc[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (clr_datapath) begin
            n_clr++;
            clr_cyc_last = cyc;
        end
        if (shift_en) begin
            if (n_shift < 16) begin
                samp[n_shift] = sample_bit;
                idxv[n_shift] = bit_idx;
                scyc[n_shift] = cyc;
            end
            n_shift++;
        end
        if (frame_done) begin
            if (n_done == 0) done_cyc_first = cyc;
            n_done++;
        end
        if (frame_err) n_err++;
        if (busy) n_busy_cyc++;
        if (prev_done && busy) n_busy_after_done++;
        prev_done = frame_done;
        if (32'(clr_datapath) + 32'(shift_en) + 32'(frame_done) + 32'(frame_err) > 1) n_overlap++;
    end

    // Called right after a negedge; returns on a negedge with the line idle again.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len);
        rx_in = 1'b0;
        edge_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (stop_len) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic check_bits(input string tag, input logic [7:0] d, input int base);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s_sample%0d", tag, i), 32'(samp[base+i]), 32'(d[i]));
            check($sformatf("%s_idx%0d", tag, i), 32'(idxv[base+i]), i);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         stop_len;
        logic       en;
        int         exp_clr;
        int         exp_shift;
        int         exp_done;
        int         exp_err;
        int         exp_busy;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Busy spans from the cycle after detect through the stop sample (152)
        // or, for a low stop bit, until the line has been high long enough to resync (184).
        vecs[0] = '{8'hA5, 1'b1, 16, 1'b1, 1, 8, 1, 0, 152};
        vecs[1] = '{8'h3C, 1'b0, 40, 1'b1, 1, 8, 0, 1, 184};
        vecs[2] = '{8'h55, 1'b1, 16, 1'b0, 0, 0, 0, 0, 0};
        vecs[3] = '{8'h81, 1'b1, 16, 1'b1, 1, 8, 1, 0, 152};

        clear_log();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'({clr_datapath, shift_en, sample_bit, frame_done, frame_err, busy, bit_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            clear_log();
            enable = vecs[v].en;
            send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].stop_len);
            repeat (30) @(negedge clk);
            #1;
            check($sformatf("v%0d_clr", v), n_clr, vecs[v].exp_clr);
            check($sformatf("v%0d_shifts", v), n_shift, vecs[v].exp_shift);
            check($sformatf("v%0d_done", v), n_done, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), n_err, vecs[v].exp_err);
            check($sformatf("v%0d_busy_cycles", v), n_busy_cyc, vecs[v].exp_busy);
            check($sformatf("v%0d_overlap", v), n_overlap, 0);
            check($sformatf("v%0d_busy_after_done", v), n_busy_after_done, 0);
            if (vecs[v].exp_shift == NB && n_shift == NB) begin
                check($sformatf("v%0d_first_shift_latency", v), scyc[0] - edge_cyc, 26);
                for (int i = 1; i < NB; i++)
                    check($sformatf("v%0d_spacing%0d", v, i), scyc[i] - scyc[i-1], CPB);
                check_bits($sformatf("v%0d", v), vecs[v].data, 0);
            end
            enable = 1'b1;
        end

        // Start glitch: line low for 4 cycles only.
        clear_log();
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("glitch_clr", n_clr, 1);
        check("glitch_shifts", n_shift, 0);
        check("glitch_done_err", n_done + n_err, 0);
        check("glitch_busy_cycles", n_busy_cyc, 8);

        // Enable dropped mid-frame: the frame still completes.
        @(negedge clk);
        clear_log();
        fork
            send_frame(8'h5A, 1'b1, 16);
            begin
                repeat (40) @(negedge clk);
                enable = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        #1;
        check("en_drop_shifts", n_shift, 8);
        check("en_drop_done", n_done, 1);
        check("en_drop_err", n_err, 0);
        if (n_shift == NB) check_bits("en_drop", 8'h5A, 0);
        enable = 1'b1;

        // Reset asserted after the third data sample, held until the line is idle.
        @(negedge clk);
        clear_log();
        fork
            send_frame(8'hF0, 1'b1, 16);
            begin
                int k;
                k = 0;
                while (n_shift < 3 && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                check("rst_wait_third_shift", 32'(k < 400), 1);
                #2 rst_n = 1'b0;
                #1;
                check("rst_mid_outputs", 32'({clr_datapath, shift_en, sample_bit, frame_done, frame_err, busy, bit_idx}), 0);
            end
        join
        repeat (5) @(negedge clk);
        check("rst_mid_shifts", n_shift, 3);
        check("rst_mid_done_err", n_done + n_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_log();
        send_frame(8'h81, 1'b1, 16);
        repeat (30) @(negedge clk);
        #1;
        check("post_rst_shifts", n_shift, 8);
        check("post_rst_done", n_done, 1);
        if (n_shift == NB) check_bits("post_rst", 8'h81, 0);

        // Back-to-back: second start edge follows the stop bit with no idle gap.
        @(negedge clk);
        clear_log();
        send_frame(8'h00, 1'b1, 9);
        send_frame(8'hFF, 1'b1, 16);
        repeat (30) @(negedge clk);
        #1;
        check("b2b_clr", n_clr, 2);
        check("b2b_shifts", n_shift, 16);
        check("b2b_done", n_done, 2);
        check("b2b_err", n_err, 0);
        check("b2b_overlap", n_overlap, 0);
        check("b2b_detect_after_done", clr_cyc_last - done_cyc_first, 1);
        if (n_shift == 2 * NB) begin
            check_bits("b2b_f0", 8'h00, 0);
            check_bits("b2b_f1", 8'hFF, NB);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
